fsm_link_host: RTL
==================

// Module: fsm_link_host
// PURPOSE
//  Host-side initiator for the nibble-serial compute link driven by fsm_design.
//  Takes one 64-bit operand pair plus an op_val program over a valid/ready request port.
//  Pulses start, serialises a/b LSB-nibble-first, then plays the op_val program.
//  Collects the nibble-serial result into one word on a valid/ready response port.
// PARAMETERS
//  N        64   operand/result width; N % N_width == 0
//  N_width  4    link nibble width; BEATS = N/N_width (localparam, 16 by default)
//  OPS      8    max op_val program length (steps)
//  TIMEOUT  255  max idle cycles waiting for out_valid before abort
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              synchronous active-low reset
//  req_valid    in   1              request offered
//  req_ready    out  1              high only in IDLE
//  req_a        in   N              operand a
//  req_b        in   N              operand b
//  req_ops      in   2*OPS          program; step k = req_ops[2k+:2]
//  req_num_ops  in   $clog2(OPS+1)  steps used, 0..OPS (values >OPS clamp to OPS)
//  start        out  1              to fsm_design start
//  input_enable out  1              to fsm_design input_enable
//  a_nib        out  N_width        to fsm_design a
//  b_nib        out  N_width        to fsm_design b
//  op_val       out  2              to fsm_design op_val
//  out_nib      in   N_width        from fsm_design out
//  out_valid    in   1              from fsm_design output_valid
//  rsp_valid    out  1              response held until accepted
//  rsp_ready    in   1              response accepted
//  rsp_data     out  N              collected result
//  rsp_timeout  out  1              1 = aborted on timeout; rsp_data is partial
// BEHAVIOUR
//  Reset (rst_n low at an edge, any state) -> IDLE, all outputs 0 except req_ready=1, counters/regs 0.
//  Reset mid-transaction: the pending request and the response are dropped. The far end shares rst_n.
//  IDLE:    req_ready=1. req_valid&&req_ready latches a, b, ops, num_ops -> START.
//  START:   start=1 for exactly one cycle -> SEND.
//  SEND:    BEATS cycles; input_enable=1; a_nib/b_nib = reg[k*N_width+:N_width], k=0..BEATS-1; op_val=0.
//           After beat BEATS-1 -> OPS. There are no gaps between beats.
//  OPS:     one step per cycle; op_val=step k, k=0..num_ops-1. input_enable=0.
//           After the last step -> WAIT. num_ops==0 goes straight to WAIT.
//  WAIT:    op_val held at 2'd1 (forces S4->OUTPUT). Timeout counter increments each cycle.
//           out_valid=1 -> COLLECT and capture in the same cycle.
//           Counter reaching TIMEOUT -> RESP with rsp_timeout=1.
//  COLLECT: each cycle with out_valid=1, capture out_nib into rsp_data[j*N_width+:N_width] and j++.
//           After j reaches BEATS -> RESP, rsp_timeout=0.
//           A cycle with out_valid=0 before j reaches BEATS does not advance j. It counts toward the timeout.
//  RESP:    rsp_valid=1. rsp_data and rsp_timeout are stable until rsp_valid&&rsp_ready -> IDLE.
//           req_ready stays 0 here.
//  Timeout counter: cleared on entry to WAIT and on every captured nibble.
//  out_valid outside WAIT/COLLECT is ignored. rsp_data is cleared on leaving IDLE.
//  Latency with num_ops=P and no stalls: accept -> rsp_valid = 1+BEATS+P+1+BEATS cycles.
//  For the defaults with P=2 this is 36 cycles.
// TESTING (bench = this block looped to an fsm_design instance, shared clk/rst_n)
//  1. After reset: a=5, b=3, ops={2,1} -> link S0->S4->OUTPUT; rsp_data=64'h7, rsp_timeout=0, latency 36.
//  2. a=64'hFEDCBA9876543210, b=0, ops={} -> SEND a_nib sequence is 0,1..F. op_val stuck at 1 (S0 loops).
//     Required: rsp_timeout=1 after 255 WAIT cycles, rsp_data=0.
//  3. Test 1 with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_timeout stay stable.
//     req_ready=0 throughout; the transaction completes on the first rsp_ready=1.
//  4. rst_n low for one cycle at SEND beat 7 -> next cycle IDLE, start/input_enable=0, req_ready=1.
//     A following test-1 request still returns 64'h7.
//  5. Scoreboard model of the far end: out_valid de-asserted for 3 cycles after nibble 4.
//     Required: j holds at 5, no timeout, and the 64-bit word is assembled correctly.
//  6. req_num_ops=OPS+3 -> only OPS steps are played, then WAIT with op_val=1.

Source files
------------

// File: rtl/fsm_link_host.sv
// Host-side initiator for the nibble-serial compute link: accepts an operand pair and op program,
// streams them to the far end and collects the nibble-serial result into one response word.
module fsm_link_host #(
    parameter int unsigned N       = 64,
    parameter int unsigned N_width = 4,
    parameter int unsigned OPS     = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N-1:0]             req_a,
    input  logic [N-1:0]             req_b,
    input  logic [2*OPS-1:0]         req_ops,
    input  logic [$clog2(OPS+1)-1:0] req_num_ops,
    output logic                     start,
    output logic                     input_enable,
    output logic [N_width-1:0]       a_nib,
    output logic [N_width-1:0]       b_nib,
    output logic [1:0]               op_val,
    input  logic [N_width-1:0]       out_nib,
    input  logic                     out_valid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N-1:0]             rsp_data,
    output logic                     rsp_timeout
);

    localparam int unsigned BEATS  = N / N_width;
    localparam int unsigned IDX_W  = $clog2(BEATS + 1);
    localparam int unsigned NOPS_W = $clog2(OPS + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND, S_OPS, S_WAIT, S_COLLECT, S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0]        a_q, a_d, b_q, b_d;
    logic [2*OPS-1:0]    ops_q, ops_d;
    logic [NOPS_W-1:0]   nops_q, nops_d, step_q, step_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [N-1:0]        rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                req_ready_q, req_ready_d;
    logic                start_q, start_d;
    logic                input_enable_q, input_enable_d;
    logic [N_width-1:0]  a_nib_q, a_nib_d, b_nib_q, b_nib_d;
    logic [1:0]          op_val_q, op_val_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_hit;
    logic             last_beat;
    logic             ops_done;

    // idx_q counts SEND beats, then collected nibbles (j)
    assign tmo_inc   = tmo_q + TMO_W'(1);
    assign tmo_hit   = (tmo_inc == TMO_W'(TIMEOUT));
    assign last_beat = (idx_q == IDX_W'(BEATS - 1));
    assign ops_done  = (step_q == nops_q);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (last_beat) state_d = (nops_q == '0) ? S_WAIT : S_OPS;
            S_OPS:   if (ops_done) state_d = S_WAIT;
            S_WAIT, S_COLLECT: begin
                if (out_valid) begin
                    if (last_beat)              state_d = S_RESP;
                    else if (state_q == S_WAIT) state_d = S_COLLECT;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all computed against the next state
    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        ops_d         = ops_q;
        nops_d        = nops_q;
        step_d        = step_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        a_nib_d       = '0;
        b_nib_d       = '0;
        op_val_d      = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (state_d == S_START) begin
                    a_d           = req_a;
                    b_d           = req_b;
                    ops_d         = req_ops;
                    nops_d        = (req_num_ops > NOPS_W'(OPS)) ? NOPS_W'(OPS) : req_num_ops;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
            S_START, S_SEND: begin
                if (state_d == S_SEND) begin
                    idx_d   = (state_q == S_START) ? '0 : idx_q + IDX_W'(1);
                    a_nib_d = a_q[N_width-1:0];
                    b_nib_d = b_q[N_width-1:0];
                    a_d     = a_q >> N_width;
                    b_d     = b_q >> N_width;
                end else if (state_d == S_OPS) begin
                    op_val_d = ops_q[1:0];
                    ops_d    = ops_q >> 2;
                    step_d   = NOPS_W'(1);
                end
            end
            S_OPS: begin
                if (state_d == S_OPS) begin
                    op_val_d = ops_q[1:0];
                    ops_d    = ops_q >> 2;
                    step_d   = step_q + NOPS_W'(1);
                end
            end
            S_WAIT, S_COLLECT: begin
                if (out_valid) begin
                    rsp_data_d[idx_q*N_width +: N_width] = out_nib;
                    idx_d = idx_q + IDX_W'(1);
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
                if (state_d == S_RESP) rsp_timeout_d = !out_valid;
            end
            default: ;
        endcase

        // Entering WAIT restarts the nibble index and the idle-cycle counter
        if (state_d == S_WAIT && state_q != S_WAIT) begin
            idx_d = '0;
            tmo_d = '0;
        end
        if (state_d == S_WAIT) op_val_d = 2'd1;

        req_ready_d    = (state_d == S_IDLE);
        start_d        = (state_d == S_START);
        input_enable_d = (state_d == S_SEND);
        rsp_valid_d    = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q            <= '0;
            b_q            <= '0;
            ops_q          <= '0;
            nops_q         <= '0;
            step_q         <= '0;
            idx_q          <= '0;
            tmo_q          <= '0;
            rsp_data_q     <= '0;
            rsp_timeout_q  <= 1'b0;
            req_ready_q    <= 1'b1;
            start_q        <= 1'b0;
            input_enable_q <= 1'b0;
            a_nib_q        <= '0;
            b_nib_q        <= '0;
            op_val_q       <= 2'd0;
            rsp_valid_q    <= 1'b0;
        end else begin
            a_q            <= a_d;
            b_q            <= b_d;
            ops_q          <= ops_d;
            nops_q         <= nops_d;
            step_q         <= step_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            rsp_data_q     <= rsp_data_d;
            rsp_timeout_q  <= rsp_timeout_d;
            req_ready_q    <= req_ready_d;
            start_q        <= start_d;
            input_enable_q <= input_enable_d;
            a_nib_q        <= a_nib_d;
            b_nib_q        <= b_nib_d;
            op_val_q       <= op_val_d;
            rsp_valid_q    <= rsp_valid_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign start        = start_q;
    assign input_enable = input_enable_q;
    assign a_nib        = a_nib_q;
    assign b_nib        = b_nib_q;
    assign op_val       = op_val_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule
